// File: rtl/lat_ram_resp_if.sv
// Processor-RAM request bus: the requester drives REN/WEN/address/data,
// the responder returns load data and the 2-bit RAM state.
interface lat_ram_resp_if;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport master (
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramstate
  );

  modport slave (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );
endinterface

// File: rtl/lat_ram_resp.sv
// Word-addressed RAM responder with LAT wait cycles per access and the
// FREE/BUSY/ACCESS/ERROR state encoding on a combinational ramstate.
module lat_ram_resp #(
  parameter int LAT   = 2,
  parameter int DEPTH = 16384
) (
  input  logic          CLK,
  input  logic          nRST,
  lat_ram_resp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;

  logic [31:0]   mem [DEPTH];
  logic [3:0]    cnt, cnt_n;
  logic          act, act_n;
  logic [AW-1:0] last_addr, last_addr_n;
  logic          last_wen, last_wen_n;

  logic [AW-1:0] idx;
  logic          out_of_range;
  logic          continuing;
  logic [3:0]    eff_cnt;
  ramstate_t     state;
  logic          unused_addr_lsbs;

  assign idx              = bus.ramaddr[AW+1:2];
  assign out_of_range     = |bus.ramaddr[31:AW+2];
  assign unused_addr_lsbs = ^bus.ramaddr[1:0];
  assign continuing       = act && (idx == last_addr) && (bus.ramWEN == last_wen);
  assign eff_cnt          = continuing ? cnt : 4'd0;

  // State register: the only place request bookkeeping is held.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments keep every register sampling the pre-edge values.
    if (!nRST) begin
      cnt       <= 4'd0;
      act       <= 1'b0;
      last_addr <= '0;
      last_wen  <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      act       <= act_n;
      last_addr <= last_addr_n;
      last_wen  <= last_wen_n;
    end
  end

  // Next-state: only BUSY keeps a transaction alive; ACCESS/FREE/ERROR close it.
  always_comb begin
    // NOTE: defaults on every path so no latch is inferred.
    cnt_n       = 4'd0;
    act_n       = 1'b0;
    last_addr_n = last_addr;
    last_wen_n  = last_wen;
    if (state == BUSY) begin
      cnt_n       = eff_cnt + 4'd1;
      act_n       = 1'b1;
      last_addr_n = idx;
      last_wen_n  = bus.ramWEN;
    end
  end

  // Outputs. With LAT=0 a fresh request has eff_cnt=0=LAT, so it is ACCESS at once.
  always_comb begin
    state = BUSY;
    if (!bus.ramREN && !bus.ramWEN)        state = FREE;
    else if (bus.ramREN && bus.ramWEN)     state = ERROR;
    else if (out_of_range)                 state = ERROR;
    else if (eff_cnt == 4'(LAT))           state = ACCESS;

    bus.ramload = 32'd0;
    if (state == ACCESS && bus.ramREN) bus.ramload = mem[idx];
  end

  assign bus.ramstate = state;

  // NOTE: the array has no reset; contents survive nRST and only ACCESS writes it.
  always_ff @(posedge CLK) begin
    if (nRST && state == ACCESS && bus.ramWEN) mem[idx] <= bus.ramstore;
  end
endmodule

// File: tb/tb_lat_ram_resp.sv
// Drives four responders (LAT = 2, 0, 3, 1) with directed and random requests
// and compares them against a transaction-level model of the RAM.
module tb_lat_ram_resp;
  localparam int DEPTH = 16384;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic        CLK = 1'b0;
  logic        nrst  [4];
  logic        ren   [4];
  logic        wen   [4];
  logic [31:0] addr  [4];
  logic [31:0] store [4];
  logic [31:0] load  [4];
  logic [1:0]  st    [4];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    lat_ram_resp_if bus ();
    assign bus.ramREN   = ren[g];
    assign bus.ramWEN   = wen[g];
    assign bus.ramaddr  = addr[g];
    assign bus.ramstore = store[g];
    assign load[g]      = bus.ramload;
    assign st[g]        = bus.ramstate;
    lat_ram_resp #(.LAT(g == 0 ? 2 : g == 1 ? 0 : g == 2 ? 3 : 1), .DEPTH(DEPTH)) dut (
      .CLK  (CLK),
      .nRST (nrst[g]),
      .bus  (bus.slave)
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 0 : (k == 2) ? 3 : 1;
  endfunction

  // Model: a transaction is the current request plus how many BUSY cycles it has spent.
  bit          m_txn [4];
  int          m_idx [4];
  bit          m_wen [4];
  int          m_age [4];
  logic [31:0] m_mem [int];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // One cycle: drive instance i, leave the others idle, check i against the model.
  task automatic step(input int i, input bit r, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input bit rn,
                      output logic [1:0] os, output logic [31:0] ol);
    @(negedge CLK);
    for (int k = 0; k < 4; k++) begin
      ren[k] = 1'b0; wen[k] = 1'b0; addr[k] = 32'd0; store[k] = 32'd0; nrst[k] = 1'b1;
    end
    ren[i] = r; wen[i] = w; addr[i] = a; store[i] = d; nrst[i] = rn;
    #1;
    for (int k = 0; k < 4; k++) begin
      logic [1:0]  es;
      logic [31:0] el;
      bit          el_known;
      int          idx;
      int          age;
      idx = int'(addr[k][15:2]);
      if (!ren[k] && !wen[k])          es = FREE;
      else if (ren[k] && wen[k])       es = ERROR;
      else if (addr[k][31:16] != 16'd0) es = ERROR;
      else begin
        age = (m_txn[k] && m_idx[k] == idx && m_wen[k] == wen[k]) ? m_age[k] : 0;
        es  = (age == lat_of(k)) ? ACCESS : BUSY;
      end
      el = 32'd0;
      el_known = 1'b1;
      if (es == ACCESS && ren[k]) begin
        el_known = m_mem.exists(k * 65536 + idx);
        if (el_known) el = m_mem[k * 65536 + idx];
      end
      if (k == i) begin
        check($sformatf("model_state[%0d]", k), {30'd0, st[k]}, {30'd0, es});
        if (el_known) check($sformatf("model_load[%0d]", k), load[k], el);
      end
      if (!nrst[k]) m_txn[k] = 1'b0;
      else if (es == ACCESS) begin
        if (wen[k]) m_mem[k * 65536 + idx] = store[k];
        m_txn[k] = 1'b0;
      end else if (es == BUSY) begin
        if (!(m_txn[k] && m_idx[k] == idx && m_wen[k] == wen[k])) m_age[k] = 0;
        m_txn[k] = 1'b1;
        m_idx[k] = idx;
        m_wen[k] = wen[k];
        m_age[k] = m_age[k] + 1;
      end else m_txn[k] = 1'b0;
    end
    os = st[i];
    ol = load[i];
  endtask

  // Hold one request for n cycles; expect em in all but the last cycle, ef then.
  task automatic hold(input int i, input bit r, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input int n, input logic [1:0] em,
                      input logic [1:0] ef, input logic [31:0] el, input string tag);
    logic [1:0]  os;
    logic [31:0] ol;
    for (int j = 0; j < n; j++) begin
      step(i, r, w, a, d, 1'b1, os, ol);
      check($sformatf("%s_state%0d", tag, j), {30'd0, os}, {30'd0, (j < n - 1) ? em : ef});
      check($sformatf("%s_load%0d", tag, j), ol, (j < n - 1) ? 32'd0 : el);
    end
  endtask

  task automatic idle(input int i);
    logic [1:0]  os;
    logic [31:0] ol;
    step(i, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, os, ol);
  endtask

  initial begin
    logic [1:0]  os;
    logic [31:0] ol;
    for (int k = 0; k < 4; k++) begin
      nrst[k] = 1'b0; ren[k] = 1'b0; wen[k] = 1'b0; addr[k] = 32'd0; store[k] = 32'd0;
      m_txn[k] = 1'b0; m_idx[k] = 0; m_wen[k] = 1'b0; m_age[k] = 0;
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset_state[%0d]", k), {30'd0, st[k]}, {30'd0, FREE});
      check($sformatf("reset_load[%0d]", k), load[k], 32'd0);
    end

    // Known contents for words 0..7 of every instance.
    for (int k = 0; k < 4; k++)
      for (int wd = 0; wd < 8; wd++) begin
        hold(k, 1'b0, 1'b1, 32'(wd * 4), 32'hC0DE_0000 | 32'(k << 8) | 32'(wd),
             lat_of(k) + 1, BUSY, ACCESS, 32'd0, "prefill");
        idle(k);
      end

    // Write then read at LAT=2.
    hold(0, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 3, BUSY, ACCESS, 32'd0, "wr_lat2");
    idle(0);
    hold(0, 1'b1, 1'b0, 32'h40, 32'd0, 3, BUSY, ACCESS, 32'hDEAD_BEEF, "rd_lat2");

    // LAT=0: ACCESS in the request cycle.
    hold(1, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 1, BUSY, ACCESS, 32'd0, "wr_lat0");
    idle(1);
    hold(1, 1'b1, 1'b0, 32'h40, 32'd0, 1, BUSY, ACCESS, 32'hDEAD_BEEF, "rd_lat0");

    // Address change mid-request at LAT=3 restarts the count.
    hold(2, 1'b1, 1'b0, 32'h10, 32'd0, 2, BUSY, BUSY, 32'd0, "chg_first");
    hold(2, 1'b1, 1'b0, 32'h14, 32'd0, 4, BUSY, ACCESS, 32'hC0DE_0205, "chg_second");
    idle(2);

    // Errors leave memory alone; a legal request then starts from count 0.
    hold(0, 1'b1, 1'b1, 32'h40, 32'h0BAD_F00D, 3, ERROR, ERROR, 32'd0, "err_both");
    hold(0, 1'b1, 1'b0, 32'h0001_0000, 32'd0, 2, ERROR, ERROR, 32'd0, "err_range");
    hold(0, 1'b1, 1'b0, 32'h40, 32'd0, 3, BUSY, ACCESS, 32'hDEAD_BEEF, "err_recover");
    idle(0);

    // Reset on the edge that would have written: no write happens.
    hold(0, 1'b0, 1'b1, 32'h80, 32'd0, 3, BUSY, ACCESS, 32'd0, "rst_prewrite");
    step(0, 1'b0, 1'b1, 32'h80, 32'h1234_5678, 1'b1, os, ol);
    step(0, 1'b0, 1'b1, 32'h80, 32'h1234_5678, 1'b1, os, ol);
    step(0, 1'b0, 1'b1, 32'h80, 32'h1234_5678, 1'b0, os, ol);
    check("rst_at_access_state", {30'd0, os}, {30'd0, ACCESS});
    idle(0);
    hold(0, 1'b1, 1'b0, 32'h80, 32'd0, 3, BUSY, ACCESS, 32'd0, "rst_nowrite_rd");
    // Reset in cycle 1 of a write, then a full sequence after release.
    step(0, 1'b0, 1'b1, 32'h80, 32'h1234_5678, 1'b1, os, ol);
    check("rst_mid_c0", {30'd0, os}, {30'd0, BUSY});
    step(0, 1'b0, 1'b1, 32'h80, 32'h1234_5678, 1'b0, os, ol);
    check("rst_mid_c1", {30'd0, os}, {30'd0, BUSY});
    hold(0, 1'b0, 1'b1, 32'h80, 32'h1234_5678, 3, BUSY, ACCESS, 32'd0, "rst_after");
    idle(0);
    hold(0, 1'b1, 1'b0, 32'h80, 32'd0, 3, BUSY, ACCESS, 32'h1234_5678, "rst_readback");

    // Back-to-back hold at LAT=1.
    for (int j = 0; j < 3; j++)
      hold(3, 1'b1, 1'b0, 32'h0, 32'd0, 2, BUSY, ACCESS, 32'hC0DE_0300, "b2b");
    idle(3);

    // Random traffic against the model.
    for (int k = 0; k < 4; k++) begin
      bit          r, w, rn;
      logic [31:0] a, d;
      int          kind;
      r = 1'b0; w = 1'b0; a = 32'd0; d = 32'd0;
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          kind = $urandom_range(0, 9);
          r = (kind >= 1 && kind <= 4) || kind == 9;
          w = kind >= 5;
          a = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
          if ($urandom_range(0, 15) == 0) a = a | (32'h0001_0000 << $urandom_range(0, 15));
        end
        if ($urandom_range(0, 7) == 0) d = $urandom;
        rn = ($urandom_range(0, 39) != 0);
        step(k, r, w, a, d, rn, os, ol);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
